// File: rtl/hazard_ctrl_if.sv
// Hazard controller bus: pipeline-side hazard inputs and the stall/flush/PC controls it returns.
interface hazard_ctrl_if #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned CNT_W      = 32
);
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic                  id_uses_rs1;
    logic                  id_uses_rs2;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  ex_mem_read;
    logic                  ex_branch_taken;
    logic                  mem_req;
    logic                  mem_ready;

    logic                  pc_en;
    logic                  pc_sel_target;
    logic                  stall_if_id;
    logic                  flush_if_id;
    logic                  flush_id_ex;
    logic                  stall_id_ex;
    logic                  stall_ex_mem;
    logic                  mem_timeout;
    logic [CNT_W-1:0]      stall_cycles;
    logic [CNT_W-1:0]      flush_count;

    modport master (
        output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
               ex_branch_taken, mem_req, mem_ready,
        input  pc_en, pc_sel_target, stall_if_id, flush_if_id, flush_id_ex,
               stall_id_ex, stall_ex_mem, mem_timeout, stall_cycles, flush_count
    );

    modport slave (
        input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
               ex_branch_taken, mem_req, mem_ready,
        output pc_en, pc_sel_target, stall_if_id, flush_if_id, flush_id_ex,
               stall_id_ex, stall_ex_mem, mem_timeout, stall_cycles, flush_count
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Stall/flush controller for the 5-stage core: memory wait > taken branch > load-use.
// Optional performance counters are built when HAZARD_PERF_EN is defined.
module hazard_ctrl #(
    parameter int unsigned REG_ADDR_W  = 5,
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic          clk,
    input  logic          rst,
    hazard_ctrl_if.slave  hif
);
    localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {RUN, MEM_WAIT, HALT} state_t;

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              timeout_q;

    logic mem_stall;
    logic load_use;
    logic rs1_hit;
    logic rs2_hit;

    logic pc_en_c;
    logic pc_sel_c;
    logic stall_if_id_c;
    logic flush_if_id_c;
    logic flush_id_ex_c;
    logic stall_back_c;

    assign mem_stall = hif.mem_req & ~hif.mem_ready;
    assign rs1_hit   = hif.id_uses_rs1 & (hif.id_rs1 == hif.ex_rd);
    assign rs2_hit   = hif.id_uses_rs2 & (hif.id_rs2 == hif.ex_rd);
    assign load_use  = hif.ex_mem_read & (hif.ex_rd != REG_ADDR_W'(0)) & (rs1_hit | rs2_hit);

    // Wait tracker: counts consecutive memory-stall cycles, halts on the MEM_TIMEOUT-th
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (mem_stall) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= WAIT_W'(1);
                    end
                end
                MEM_WAIT: begin
                    if (!mem_stall) begin
                        state    <= RUN;
                        wait_cnt <= '0;
                    end else if (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1)) begin
                        state     <= HALT;
                        timeout_q <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                HALT:    state <= HALT;
                default: state <= RUN;
            endcase
        end
    end

    // Control decode; zero latency, fixed priority
    always_comb begin
        pc_en_c       = 1'b1;
        pc_sel_c      = 1'b0;
        stall_if_id_c = 1'b0;
        flush_if_id_c = 1'b0;
        flush_id_ex_c = 1'b0;
        stall_back_c  = 1'b0;
        if ((state == HALT) || mem_stall) begin
            pc_en_c       = 1'b0;
            stall_if_id_c = 1'b1;
            stall_back_c  = 1'b1;
        end else if (hif.ex_branch_taken) begin
            pc_sel_c      = 1'b1;
            flush_if_id_c = 1'b1;
            flush_id_ex_c = 1'b1;
        end else if (load_use) begin
            pc_en_c       = 1'b0;
            stall_if_id_c = 1'b1;
            flush_id_ex_c = 1'b1;
        end
    end

    assign hif.pc_en         = pc_en_c;
    assign hif.pc_sel_target = pc_sel_c;
    assign hif.stall_if_id   = stall_if_id_c;
    assign hif.flush_if_id   = flush_if_id_c;
    assign hif.flush_id_ex   = flush_id_ex_c;
    assign hif.stall_id_ex   = stall_back_c;
    assign hif.stall_ex_mem  = stall_back_c;
    assign hif.mem_timeout   = timeout_q;

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    // Saturating counters; a halted core does not accumulate stall cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!pc_en_c && (state != HALT) && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush_if_id_c && (flush_cnt != '1))
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

    assign hif.stall_cycles = stall_cnt;
    assign hif.flush_count  = flush_cnt;
`else
    assign hif.stall_cycles = CNT_W'(0);
    assign hif.flush_count  = CNT_W'(0);
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized bench for hazard_ctrl against a cycle-level reference model of the hazard rules.
module tb_hazard_ctrl;
    localparam int unsigned RW = 5;
    localparam int unsigned TO = 4;
    localparam int unsigned CW = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    hazard_ctrl_if #(.REG_ADDR_W(RW), .CNT_W(CW)) hif();

    hazard_ctrl #(.REG_ADDR_W(RW), .MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .hif (hif.slave)
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Reference model state: halted flag, run length of consecutive memory stalls, counters
    bit          m_halt;
    int          m_consec;
    logic [CW-1:0] m_stall;
    logic [CW-1:0] m_flush;

    logic e_pc_en, e_sel, e_sif, e_fif, e_fie, e_sback;
    bit   e_mstall;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_comb();
        bit lu;
        e_mstall = hif.mem_req && !hif.mem_ready;
        lu = hif.ex_mem_read && (hif.ex_rd != 0) &&
             ((hif.id_uses_rs1 && hif.id_rs1 == hif.ex_rd) ||
              (hif.id_uses_rs2 && hif.id_rs2 == hif.ex_rd));
        e_pc_en = 1; e_sel = 0; e_sif = 0; e_fif = 0; e_fie = 0; e_sback = 0;
        if (m_halt || e_mstall) begin
            e_pc_en = 0; e_sif = 1; e_sback = 1;
        end else if (hif.ex_branch_taken) begin
            e_sel = 1; e_fif = 1; e_fie = 1;
        end else if (lu) begin
            e_pc_en = 0; e_sif = 1; e_fie = 1;
        end
    endtask

    task automatic model_reset();
        m_halt = 0; m_consec = 0; m_stall = '0; m_flush = '0;
    endtask

    task automatic model_update();
        model_comb();
        if (!m_halt && !e_pc_en && m_stall != '1) m_stall = m_stall + 1;
        if (e_fif && m_flush != '1) m_flush = m_flush + 1;
        if (!m_halt) begin
            if (e_mstall) begin
                m_consec++;
                if (m_consec == TO) m_halt = 1;
            end else begin
                m_consec = 0;
            end
        end
    endtask

    task automatic check_outputs();
        model_comb();
        check("pc_en",         32'(hif.pc_en),         32'(e_pc_en));
        check("pc_sel_target", 32'(hif.pc_sel_target), 32'(e_sel));
        check("stall_if_id",   32'(hif.stall_if_id),   32'(e_sif));
        check("flush_if_id",   32'(hif.flush_if_id),   32'(e_fif));
        check("flush_id_ex",   32'(hif.flush_id_ex),   32'(e_fie));
        check("stall_id_ex",   32'(hif.stall_id_ex),   32'(e_sback));
        check("stall_ex_mem",  32'(hif.stall_ex_mem),  32'(e_sback));
        check("if_id_excl",    32'(hif.stall_if_id & hif.flush_if_id), 32'(0));
        check("mem_timeout",   32'(hif.mem_timeout),   32'(m_halt));
`ifdef HAZARD_PERF_EN
        check("stall_cycles",  32'(hif.stall_cycles),  32'(m_stall));
        check("flush_count",   32'(hif.flush_count),   32'(m_flush));
`else
        check("stall_cycles",  32'(hif.stall_cycles),  32'(0));
        check("flush_count",   32'(hif.flush_count),   32'(0));
`endif
    endtask

    task automatic set_in(input int rs1, input int rs2, input bit u1, input bit u2, input int rd,
                          input bit mrd, input bit br, input bit req, input bit rdy);
        hif.id_rs1          = RW'(rs1);
        hif.id_rs2          = RW'(rs2);
        hif.id_uses_rs1     = u1;
        hif.id_uses_rs2     = u2;
        hif.ex_rd           = RW'(rd);
        hif.ex_mem_read     = mrd;
        hif.ex_branch_taken = br;
        hif.mem_req         = req;
        hif.mem_ready       = rdy;
    endtask

    task automatic set_idle();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Inputs change just after the rising edge; outputs are sampled on the falling edge
    task automatic run_cycle();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_update();
        #1;
    endtask

    // Asynchronous reset asserted between edges and checked before any clock edge
    task automatic do_reset();
        set_idle();
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        model_update();
        #1;
    endtask

    initial begin
        set_idle();
        #1;
        do_reset();

        // load-use, then hazard cleared
        set_in(5, 0, 1, 0, 5, 1, 0, 0, 0); run_cycle();
        set_idle();                        run_cycle();
        // zero register never hazards
        set_in(0, 0, 1, 0, 0, 1, 0, 0, 0); run_cycle();
        // rs2 load-use
        set_in(1, 7, 1, 1, 7, 1, 0, 0, 0); run_cycle();
        // taken branch
        set_in(0, 0, 0, 0, 0, 0, 1, 0, 0); run_cycle();
        // branch together with load-use: flush only
        set_in(3, 0, 1, 0, 3, 1, 1, 0, 0); run_cycle();
        // three-cycle memory wait, release on ready
        repeat (3) begin set_in(0, 0, 0, 0, 0, 0, 0, 1, 0); run_cycle(); end
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 1); run_cycle();
        set_idle();                        run_cycle();
        // memory stall with pending branch, then branch flushes when ready
        repeat (2) begin set_in(0, 0, 0, 0, 0, 0, 1, 1, 0); run_cycle(); end
        set_in(0, 0, 0, 0, 0, 0, 1, 1, 1); run_cycle();
        set_idle();                        run_cycle();
        // timeout: stall held past MEM_TIMEOUT, ready does not release the halt
        repeat (6) begin set_in(0, 0, 0, 0, 0, 0, 0, 1, 0); run_cycle(); end
        repeat (2) begin set_in(0, 0, 0, 0, 0, 0, 1, 1, 1); run_cycle(); end
        do_reset();
        set_idle();                        run_cycle();

        for (int i = 0; i < 3000; i++) begin
            bit req;
            req = 1'($urandom_range(0, 1));
            set_in(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 5) == 0), req, ($urandom_range(0, 2) == 0));
            run_cycle();
            if (m_halt ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 299) == 0))
                do_reset();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall controller for the 5-stage core; it generates the STALL/FLUSH controls for the IF/ID register, bubble insertion for ID/EX, backend freezes and PC write/select. It resolves three hazard sources each cycle in fixed priority: data-memory wait, taken branch/jump, load-use. A small FSM tracks multi-cycle memory waits and halts the core on a memory timeout.

## Interface
- REG_ADDR_W, 5: register-index width
- MEM_TIMEOUT, 16: consecutive memory-wait cycles before halt (≥2)
- CNT_W, 32: performance counter width
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- id_rs1, id_rs2  in  REG_ADDR_W  source registers of the instruction in IF/ID
- id_uses_rs1, id_uses_rs2  in  1  instruction in IF/ID reads rs1 / rs2
- ex_rd  in  REG_ADDR_W  destination of the instruction in ID/EX
- ex_mem_read  in  1  instruction in ID/EX is a load
- ex_branch_taken  in  1  branch/jump in EX resolved taken
- mem_req  in  1  MEM-stage instruction accesses data memory
- mem_ready  in  1  data memory completes the access this cycle
- pc_en  out  1  PC register write enable
- pc_sel_target  out  1  1: PC loads the EX branch target
- stall_if_id  out  1  hold IF/ID (to its STALL)
- flush_if_id  out  1  clear IF/ID (to its FLUSH)
- flush_id_ex  out  1  load a bubble into ID/EX
- stall_id_ex, stall_ex_mem  out  1  hold the backend registers
- mem_timeout  out  1  sticky timeout flag
- stall_cycles, flush_count  out  CNT_W  performance counters

## Operation
- mem_stall = mem_req & ~mem_ready.
- load_use = ex_mem_read & (ex_rd≠0) & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
- Outputs are combinational from state and inputs, with priority top-down:
  - HALT state: pc_en=0; stall_if_id, stall_id_ex, stall_ex_mem=1; flushes=0.
  - mem_stall: same as HALT. An EX branch is held, not flushed.
  - ex_branch_taken: pc_en=1, pc_sel_target=1, flush_if_id=1, flush_id_ex=1.
  - load_use: pc_en=0, stall_if_id=1, flush_id_ex=1 (one bubble).
  - Otherwise: pc_en=1, all other controls 0.
- flush_if_id and stall_if_id are never asserted together.
- FSM states: RUN, MEM_WAIT, HALT; wait_cnt is $clog2(MEM_TIMEOUT+1) bits.
  - RUN: mem_stall → MEM_WAIT with wait_cnt=1; else stay.
  - MEM_WAIT: mem_ready or ~mem_req → RUN with wait_cnt=0. If mem_stall and wait_cnt==MEM_TIMEOUT-1 → HALT. Otherwise mem_stall increments wait_cnt.
  - HALT: terminal until rst; mem_timeout=1.

## Timing
- Reset (async) values:
  - state=RUN, wait_cnt=0, mem_timeout=0, counters=0.
  - Combinational outputs then follow the RUN priority rules: pc_en=1, all other controls 0 when inputs are idle.
- Control latency is zero; control outputs are valid in the same cycle as their inputs.
- Load-use costs exactly 1 stall cycle. A taken branch costs 2 flushed slots (IF/ID and ID/EX).
- Mem wait of N cycles gives N stall cycles. The stall releases in the cycle mem_ready=1.
- Timeout: HALT is entered at the edge ending the MEM_TIMEOUT-th consecutive mem_stall cycle. mem_timeout is high from the next cycle on.
- Simultaneous events:
  - mem_stall + branch: stall only; the branch flushes in the first non-stalled cycle.
  - branch + load_use: flush only; the load-use instruction is discarded.
- Reset mid-wait: returns immediately to RUN with wait_cnt=0.

## Configuration
- HAZARD_PERF_EN defined:
  - stall_cycles increments every cycle pc_en=0 outside HALT.
  - flush_count increments every cycle flush_if_id=1.
  - Both counters saturate at all-ones.
- HAZARD_PERF_EN undefined: counter registers are not built; both ports are driven constant 0.

## Test plan
- Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_uses_rs1=1 for one cycle → pc_en=0, stall_if_id=1, flush_id_ex=1 that cycle; next cycle (hazard cleared) → pc_en=1.
- Zero register: same as load-use but ex_rd=0, id_rs1=0 → no stall, pc_en=1.
- Branch: ex_branch_taken=1 → flush_if_id=1, flush_id_ex=1, pc_sel_target=1, stall_if_id=0; flush_count +1.
- Mem wait: mem_req=1, mem_ready=0 for 3 cycles then mem_ready=1 → all stalls high for 3 cycles, released on cycle 4; stall_cycles=3; state back to RUN.
- Priority: mem_stall and ex_branch_taken together for 2 cycles → no flush during the stall; flush occurs on the first cycle with mem_ready=1.
- Timeout with MEM_TIMEOUT=4: mem_stall held → mem_timeout=1 from cycle 5, pc_en stays 0 even after mem_ready=1; assert rst mid-HALT → immediate RUN, mem_timeout=0.
